dog_gauss_row: RTL and testbench

- 7-tap symmetric 1-D Gaussian filter stage of the DoG pipeline.
- Consumes the mirror-padded pixel stream returned by the blur RAMs, 262 samples per line (x = -3..258), sequenced by the DoG read-address generator.
- Emits 256 filtered pixels per line with their (x, y) coordinates for the write-back stage.
- Used for both the row pass and the column pass; the pass is transparent to this block.

---
 rtl/dog_gauss_row.sv | 120 ++++++++++++
 tb/tb_dog_gauss_row.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/dog_gauss_row.sv
// 7-tap symmetric Gaussian line filter for the DoG pipeline: window shift, MAC, round.
// Optional output clamp enabled by defining DOG_GAUSS_SAT_EN.
module dog_gauss_row #(
  parameter int DW       = 8,
  parameter int LINE_LEN = 262,
  parameter int ROWS     = 256,
  parameter int K0       = 4,
  parameter int K1       = 16,
  parameter int K2       = 56,
  parameter int K3       = 104
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic [7:0]    out_x,
  output logic [7:0]    out_y,
  output logic          frame_done,
  output logic          busy
);

  localparam int          SW       = 18;
  localparam logic [8:0]  LAST_COL = 9'(LINE_LEN - 1);
  localparam logic [7:0]  LAST_ROW = 8'(ROWS - 1);
  localparam logic [SW-1:0] C0 = SW'(K0);
  localparam logic [SW-1:0] C1 = SW'(K1);
  localparam logic [SW-1:0] C2 = SW'(K2);
  localparam logic [SW-1:0] C3 = SW'(K3);
  localparam logic [SW-1:0] RND = SW'(128);

  logic [8:0]         col_cnt;
  logic [7:0]         row_cnt;
  logic [6:0][DW-1:0] win;       // win[6] newest, win[0] oldest
  logic               v0, v1;
  logic [7:0]         x0, y0, x1, y1;
  logic [SW-1:0]      sum_q, sum_c;
  logic [DW:0]        p06, p15, p24;
  logic [DW-1:0]      pix_c;
  logic               last_out;

  always_comb begin
    p06   = {1'b0, win[0]} + {1'b0, win[6]};
    p15   = {1'b0, win[1]} + {1'b0, win[5]};
    p24   = {1'b0, win[2]} + {1'b0, win[4]};
    sum_c = C0 * SW'(p06) + C1 * SW'(p15) + C2 * SW'(p24) + C3 * SW'(win[3]);
  end

`ifdef DOG_GAUSS_SAT_EN
  logic [SW-1:0] rnd;
  always_comb begin
    rnd   = (sum_q + RND) >> 8;
    pix_c = (rnd > SW'((2**DW) - 1)) ? {DW{1'b1}} : rnd[DW-1:0];
  end
`else
  // Truncation only; correct as long as the taps sum to at most 256.
  always_comb pix_c = DW'((sum_q + RND) >> 8);
`endif

  assign last_out = out_valid && (out_x == 8'd255) && (out_y == LAST_ROW);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt    <= '0;
      row_cnt    <= '0;
      win        <= '0;
      v0         <= 1'b0;
      v1         <= 1'b0;
      x0         <= '0;
      y0         <= '0;
      x1         <= '0;
      y1         <= '0;
      sum_q      <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_x      <= '0;
      out_y      <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else if (start) begin
      // start beats a coincident sample; in-flight results are discarded
      col_cnt    <= '0;
      row_cnt    <= '0;
      v0         <= 1'b0;
      v1         <= 1'b0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b1;
    end else begin
      v0 <= 1'b0;
      if (in_valid) begin
        win <= {in_data, win[6:1]};
        v0  <= (col_cnt >= 9'd6);
        x0  <= 8'(col_cnt - 9'd6);
        y0  <= row_cnt;
        if (col_cnt == LAST_COL) begin
          col_cnt <= '0;
          row_cnt <= (row_cnt == LAST_ROW) ? 8'd0 : row_cnt + 8'd1;
        end else begin
          col_cnt <= col_cnt + 9'd1;
        end
      end
      v1        <= v0;
      x1        <= x0;
      y1        <= y0;
      sum_q     <= sum_c;
      out_valid <= v1;
      if (v1) begin
        out_data <= pix_c;
        out_x    <= x1;
        out_y    <= y1;
      end
      frame_done <= last_out;
      if (last_out) busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dog_gauss_row.sv
// Directed bench for dog_gauss_row: constant, impulse, gapped, mid-frame start, full frame, clamp, reset.
module tb_dog_gauss_row;
  logic       clk = 1'b0;
  logic       rst_n, start, in_valid;
  logic [7:0] in_data;
  logic       out_valid, frame_done, busy;
  logic [7:0] out_data, out_x, out_y;
  logic       k_out_valid, k_frame_done, k_busy;
  logic [7:0] k_out_data, k_out_x, k_out_y;

  dog_gauss_row dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .out_x(out_x), .out_y(out_y),
    .frame_done(frame_done), .busy(busy));

  dog_gauss_row #(.K3(200)) dut_k (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .out_valid(k_out_valid), .out_data(k_out_data), .out_x(k_out_x), .out_y(k_out_y),
    .frame_done(k_frame_done), .busy(k_busy));

  always #5 clk = ~clk;

  typedef struct { int x; int y; int d; int t; } ev_t;
  ev_t q[$];
  int  kq[$];
  int  cyc = 0;
  int  checks = 0, failures = 0;
  int  fd_cnt = 0, fd_t = 0, fd_busy = 0, t7 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid) q.push_back('{int'(out_x), int'(out_y), int'(out_data), cyc});
    if (k_out_valid) kq.push_back(int'(k_out_data));
    if (frame_done) begin
      fd_cnt++;
      fd_t    = cyc;
      fd_busy = int'(busy);
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int imp_exp(input int x);
    case (x)
      4, 10:   return 4;
      5, 9:    return 16;
      6, 8:    return 56;
      7:       return 104;
      default: return 0;
    endcase
  endfunction

  // mode 0: constant v; mode 1: 255 at col 10, else 0
  task automatic send_line(input int mode, input int v, input int gap, input int ncols);
    for (int c = 0; c < ncols; c++) begin
      in_valid = 1'b1;
      in_data  = (mode == 1) ? ((c == 10) ? 8'd255 : 8'd0) : 8'(v);
      if (c == 6) t7 = cyc;
      step();
      in_valid = 1'b0;
      repeat (gap) step();
    end
  endtask

  task automatic chk_line(input string tag, input int y, input int mode, input int v);
    int bad = 0;
    int e;
    chk({tag, "_cnt"}, q.size(), 256);
    foreach (q[i]) begin
      e = (mode == 1) ? imp_exp(i) : v;
      if (q[i].x != i || q[i].y != y || q[i].d != e) bad++;
    end
    chk({tag, "_bad"}, bad, 0);
  endtask

  initial begin
    int bad, last_t, exp_k;
`ifdef DOG_GAUSS_SAT_EN
    exp_k = 255;
`else
    exp_k = 95;
`endif
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) step();
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    rst_n = 1'b1;
    step();
    start = 1'b1; step(); start = 1'b0;
    chk("busy_after_start", int'(busy), 1);

    q.delete();
    send_line(0, 100, 0, 262);
    repeat (4) step();
    chk_line("const", 0, 0, 100);
    chk("latency", (q.size() > 0) ? q[0].t - t7 : -1, 3);

    q.delete();
    send_line(1, 0, 0, 262);
    repeat (4) step();
    chk_line("impulse", 1, 1, 0);

    q.delete();
    send_line(0, 100, 2, 262);
    repeat (4) step();
    chk_line("gapped", 2, 0, 100);

    // line 3: start coincident with the sample at col 100
    send_line(0, 50, 0, 100);
    in_valid = 1'b1; in_data = 8'd50; start = 1'b1;
    step();
    start = 1'b0; in_valid = 1'b0;
    q.delete();
    repeat (3) step();
    chk("midstart_no_out", q.size(), 0);
    chk("midstart_busy", int'(busy), 1);
    chk("midstart_no_fd", fd_cnt, 0);
    chk("midstart_col", int'(dut.col_cnt), 0);

    q.delete(); fd_cnt = 0;
    for (int y = 0; y < 256; y++) send_line(0, y, 0, 262);
    repeat (4) step();
    chk("frame_cnt", q.size(), 65536);
    bad = 0;
    foreach (q[i]) if (q[i].x != i % 256 || q[i].y != i / 256 || q[i].d != i / 256) bad++;
    chk("frame_bad", bad, 0);
    last_t = (q.size() > 0) ? q[q.size()-1].t : -100;
    chk("fd_pulses", fd_cnt, 1);
    chk("fd_timing", fd_t - last_t, 1);
    chk("fd_busy_low", fd_busy, 0);
    chk("busy_idle", int'(busy), 0);
    chk("col_wrap", int'(dut.col_cnt), 0);
    chk("row_wrap", int'(dut.row_cnt), 0);

    // idle-state samples are still filtered; also exercises the K3=200 instance
    q.delete(); kq.delete();
    send_line(0, 255, 0, 262);
    repeat (4) step();
    chk("idle_cnt", q.size(), 256);
    chk("idle_val", (q.size() > 100) ? q[100].d : -1, 255);
    chk("k200_cnt", kq.size(), 256);
    chk("k200_val", (kq.size() > 100) ? kq[100] : -1, exp_k);
    chk("idle_busy", int'(busy), 0);

    send_line(0, 9, 0, 50);
    in_valid = 1'b1; in_data = 8'd9;
    #1 rst_n = 1'b0;
    #1;
    chk("async_out_valid", int'(out_valid), 0);
    chk("async_out_data", int'(out_data), 0);
    chk("async_col", int'(dut.col_cnt), 0);
    in_valid = 1'b0;
    q.delete();
    repeat (3) step();
    rst_n = 1'b1;
    repeat (5) step();
    chk("async_quiet", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
